// File: rtl/par2ser_feed_pkg.sv
// Shared definitions for the parallel-to-serial feeder: state encoding and
// the counter width helper.
package par2ser_feed_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Ceiling log2 with a floor of one bit, so a counter is never zero-width.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/par2ser_feed_bit_tick_gen.sv
// Bit-period counter: raises tick in the last clock of each DIV-clock bit
// period while run is high; clr restarts the period when a word is accepted.
module bit_tick_gen
   import par2ser_feed_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int W = clog2_min1(DIV);
   localparam logic [W-1:0] DIV_LAST = W'(DIV - 1);

   logic [W-1:0] div_cnt_q, div_cnt_d;

   always_comb begin
      tick      = run && (div_cnt_q == DIV_LAST);
      div_cnt_d = div_cnt_q;
      if (clr) begin
         div_cnt_d = '0;
      end else if (tick) begin
         div_cnt_d = '0;
      end else if (run) begin
         div_cnt_d = div_cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) div_cnt_q <= '0;
      else     div_cnt_q <= div_cnt_d;
   end

endmodule

// File: rtl/par2ser_feed.sv
// Parallel-to-serial feeder: accepts a word on valid/ready and drives EN/in of a
// right-shifting register LSB-first so the register ends up holding the word.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready high, waiting for a handshake
//   ST_SHIFT | presenting shreg[0] on sout, EN strobes once per bit period
//   ST_DONE  | one-cycle done pulse, no handshake accepted
module par2ser_feed
   import par2ser_feed_pkg::*;
#(
   parameter int N   = 4,
   parameter int DIV = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [N-1:0] din,
   input  logic         valid,
   output logic         ready,
   output logic         EN,
   output logic         sout,
   output logic         busy,
   output logic         done
);

   localparam int BW = clog2_min1(N);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

   state_t        state_q, state_d;
   logic [N-1:0]  shreg_q, shreg_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          tick;
   logic          accept;
   logic          run;

   assign accept = (state_q == ST_IDLE) && valid;
   assign run    = (state_q == ST_SHIFT);

   bit_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (CLK),
      .rst  (RST),
      .clr  (accept),
      .run  (run),
      .tick (tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      ready     = 1'b0;
      EN        = 1'b0;
      sout      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (valid) begin
               shreg_d   = din;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            sout = shreg_q[0];
            EN   = tick;
            if (tick) begin
               shreg_d = shreg_q >> 1;
               // Counter parks at zero on the last bit so it never passes N-1.
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = ST_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         ST_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: tb/tb_par2ser_feed.sv
// Directed bench for par2ser_feed: three instances (N=4/DIV=1, N=4/DIV=3,
// N=1/DIV=1), each feeding a model of the downstream right-shift register.
module tb_par2ser_feed;

   typedef struct {
      int         d;
      int         n;
      int         div;
      logic [3:0] din;
      logic [3:0] nxt;
      bit         hold;
      logic [3:0] exp_q;
   } vec_t;

   logic       clk = 1'b0;
   logic [2:0] rst_v;
   logic [2:0] valid_v;
   logic [3:0] din_v [3];
   wire  [2:0] ready_w, en_w, sout_w, busy_w, done_w;
   logic [3:0] q_v [3];
   int         total = 0;
   int         bad   = 0;
   vec_t       vecs [7];

   always #5 clk = ~clk;

   par2ser_feed #(.N(4), .DIV(1)) dut0 (
      .CLK(clk), .RST(rst_v[0]), .din(din_v[0]), .valid(valid_v[0]),
      .ready(ready_w[0]), .EN(en_w[0]), .sout(sout_w[0]), .busy(busy_w[0]), .done(done_w[0])
   );

   par2ser_feed #(.N(4), .DIV(3)) dut1 (
      .CLK(clk), .RST(rst_v[1]), .din(din_v[1]), .valid(valid_v[1]),
      .ready(ready_w[1]), .EN(en_w[1]), .sout(sout_w[1]), .busy(busy_w[1]), .done(done_w[1])
   );

   par2ser_feed #(.N(1), .DIV(1)) dut2 (
      .CLK(clk), .RST(rst_v[2]), .din(din_v[2][0:0]), .valid(valid_v[2]),
      .ready(ready_w[2]), .EN(en_w[2]), .sout(sout_w[2]), .busy(busy_w[2]), .done(done_w[2])
   );

   // Downstream registers: new bit enters at the MSB on each EN edge.
   always @(posedge clk) begin
      if (en_w[0]) q_v[0] <= {sout_w[0], q_v[0][3:1]};
      if (en_w[1]) q_v[1] <= {sout_w[1], q_v[1][3:1]};
      if (en_w[2]) q_v[2] <= {3'b000, sout_w[2]};
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input int d, input string tag,
                             input bit r, input bit e, input bit s, input bit b, input bit dn);
      chk($sformatf("%s d%0d ready", tag, d), {3'b0, ready_w[d]}, {3'b0, r});
      chk($sformatf("%s d%0d EN",    tag, d), {3'b0, en_w[d]},    {3'b0, e});
      chk($sformatf("%s d%0d sout",  tag, d), {3'b0, sout_w[d]},  {3'b0, s});
      chk($sformatf("%s d%0d busy",  tag, d), {3'b0, busy_w[d]},  {3'b0, b});
      chk($sformatf("%s d%0d done",  tag, d), {3'b0, done_w[d]},  {3'b0, dn});
   endtask

   // Called at a falling edge; returns at the falling edge of the cycle where
   // ready is back, so a following call models a back-to-back handshake.
   task automatic run_word(input int d, input int n, input int div, input logic [3:0] w,
                           input logic [3:0] nxt, input bit hold, input logic [3:0] exp_q);
      logic [3:0] mask;
      din_v[d]   = w;
      valid_v[d] = 1'b1;
      chk($sformatf("accept_ready d%0d", d), {3'b0, ready_w[d]}, 4'h1);
      @(posedge clk);
      for (int c = 1; c <= n * div + 2; c++) begin
         @(negedge clk);
         if (c == 1) begin
            din_v[d] = nxt;
            if (!hold) valid_v[d] = 1'b0;
         end
         if (c <= n * div)
            check_outs(d, $sformatf("shift c%0d", c), 1'b0, (c % div) == 0, w[(c - 1) / div], 1'b1, 1'b0);
         else if (c == n * div + 1)
            check_outs(d, "done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         else
            check_outs(d, "ready_back", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      mask = (n == 1) ? 4'h1 : 4'hF;
      chk($sformatf("q d%0d word %h", d, w), q_v[d] & mask, exp_q & mask);
   endtask

   initial begin
      vecs[0] = '{0, 4, 1, 4'b0110, 4'hF, 1'b0, 4'b0110};
      vecs[1] = '{0, 4, 1, 4'hA,    4'h5, 1'b1, 4'hA};
      vecs[2] = '{0, 4, 1, 4'h5,    4'h3, 1'b0, 4'h5};
      vecs[3] = '{1, 4, 3, 4'b1001, 4'h0, 1'b0, 4'b1001};
      vecs[4] = '{1, 4, 3, 4'h6,    4'h9, 1'b0, 4'h6};
      vecs[5] = '{2, 1, 1, 4'h1,    4'h0, 1'b1, 4'h1};
      vecs[6] = '{2, 1, 1, 4'h0,    4'h1, 1'b0, 4'h0};

      // Reset held with a pending handshake: nothing may be accepted.
      rst_v   = 3'b111;
      valid_v = 3'b111;
      for (int d = 0; d < 3; d++) din_v[d] = 4'hF;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         for (int d = 0; d < 3; d++) check_outs(d, "reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst_v   = 3'b000;
      valid_v = 3'b000;
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_outs(d, "post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 7; i++)
         run_word(vecs[i].d, vecs[i].n, vecs[i].div, vecs[i].din, vecs[i].nxt, vecs[i].hold, vecs[i].exp_q);

      // Reset after the 2nd strobe of 4'hC: q keeps two shifted-in zeros over 4'h5.
      din_v[0]   = 4'hC;
      valid_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_v[0] = 1'b0;
      check_outs(0, "abort c1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check_outs(0, "abort c2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      rst_v[0] = 1'b1;
      @(negedge clk);
      rst_v[0] = 1'b0;
      check_outs(0, "abort idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check_outs(0, $sformatf("abort quiet c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("abort q partial", q_v[0], 4'b0001);

      run_word(0, 4, 1, 4'h3, 4'h0, 1'b0, 4'h3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
